// File: rtl/alu_sequencer.sv
// alu_sequencer: four-phase (IDLE/READ/EXEC/WB) instruction sequencer that
// reads two registers, drives an external ALU, writes the result back and
// latches the ALU flags into a processor status register.
`timescale 1ns/1ps

module alu_sequencer #(
  parameter logic [4:0] PSR_RESET  = 5'b00000,
  parameter bit         ILLEGAL_WB = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [15:0] instr,
  output logic [3:0]  rf_raddr_a,
  output logic [3:0]  rf_raddr_b,
  input  logic [15:0] rf_rdata_a,
  input  logic [15:0] rf_rdata_b,
  output logic [15:0] alu_ctrl,
  output logic [15:0] alu_in1,
  output logic [15:0] alu_in2,
  input  logic [15:0] alu_out,
  input  logic [4:0]  alu_flags,
  output logic        rf_we,
  output logic [3:0]  rf_waddr,
  output logic [15:0] rf_wdata,
  output logic [4:0]  psr,
  output logic        done,
  output logic        illegal
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_EXEC = 2'd2,
    S_WB   = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [15:0] instr_q;
  logic [15:0] opa_q;
  logic [15:0] opb_q;
  logic [15:0] res_q;
  logic [4:0]  flags_q;
  logic [4:0]  psr_q;

  logic        accept;

  // Decoded view of the captured instruction
  logic [3:0]  op_hi;
  logic [3:0]  op_ext;
  logic        is_rtype;
  logic        imm_legal;
  logic        op_legal;
  logic        is_cmp;
  logic        is_nop;
  logic        wb_en;
  logic        psr_upd;
  logic [15:0] ctrl_word;

  assign op_hi  = instr_q[15:12];
  assign op_ext = instr_q[7:4];
  assign accept = (state_q == S_IDLE) && instr_valid;
  assign psr    = psr_q;

  // Instruction decode: legality, compare/NOP class and the ALU control word
  always_comb begin
    is_rtype  = (op_hi == 4'h0);
    imm_legal = 1'b0;
    case (op_hi)
      4'h1, 4'h2, 4'h3, 4'h5, 4'h6, 4'h7, 4'h9, 4'hB, 4'hE: imm_legal = 1'b1;
      default:                                               imm_legal = 1'b0;
    endcase
    op_legal = is_rtype || imm_legal;
    if (is_rtype) begin
      is_cmp = (op_ext == 4'hB) || (op_ext == 4'hD);
    end else begin
      is_cmp = (op_hi == 4'hB) || (op_hi == 4'h2);
    end
    is_nop = is_rtype && (op_ext == 4'h0);
    // Immediate forms move imm hi next to the opcode so the ALU sees a
    // contiguous 8-bit immediate in ctrl[11:8],ctrl[3:0].
    if (is_rtype) begin
      ctrl_word = instr_q;
    end else begin
      ctrl_word = {op_hi, op_ext, 4'b0000, instr_q[3:0]};
    end
    if (op_legal) begin
      wb_en = !(is_cmp || is_nop);
    end else begin
      wb_en = ILLEGAL_WB;
    end
    psr_upd = op_legal && !is_nop;
  end

  // State register; reset wins over every transition and aborts any instruction
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: fixed four-cycle walk once an instruction is accepted
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (instr_valid) state_d = S_READ;
      S_READ:  state_d = S_EXEC;
      S_EXEC:  state_d = S_WB;
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath registers: capture instruction, operands, ALU result and psr
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      flags_q <= '0;
      psr_q   <= PSR_RESET;
    end else begin
      if (accept) begin
        instr_q <= instr;
      end
      if (state_q == S_READ) begin
        opa_q <= rf_rdata_a;
        opb_q <= rf_rdata_b;
      end
      if (state_q == S_EXEC) begin
        res_q   <= alu_out;
        flags_q <= alu_flags;
      end
      if ((state_q == S_WB) && psr_upd) begin
        psr_q <= flags_q;
      end
    end
  end

  // Outputs decoded from the current state; WB strobes are masked by reset
  // so an instruction aborted in its last cycle leaves no trace.
  always_comb begin
    instr_ready = 1'b0;
    rf_raddr_a  = 4'h0;
    rf_raddr_b  = 4'h0;
    alu_ctrl    = 16'h0000;
    alu_in1     = 16'h0000;
    alu_in2     = 16'h0000;
    rf_we       = 1'b0;
    rf_waddr    = 4'h0;
    rf_wdata    = 16'h0000;
    done        = 1'b0;
    illegal     = 1'b0;
    case (state_q)
      S_IDLE: begin
        instr_ready = 1'b1;
        // Present the addresses in the accept cycle as well so a
        // synchronous-read register file has the data ready during READ.
        if (instr_valid) begin
          rf_raddr_a = instr[11:8];
          rf_raddr_b = instr[3:0];
        end
      end
      S_READ: begin
        rf_raddr_a = instr_q[11:8];
        rf_raddr_b = instr_q[3:0];
      end
      S_EXEC: begin
        alu_ctrl = ctrl_word;
        alu_in1  = opa_q;
        alu_in2  = opb_q;
      end
      S_WB: begin
        done     = !reset;
        illegal  = !op_legal && !reset;
        rf_we    = wb_en && !reset;
        rf_waddr = instr_q[11:8];
        rf_wdata = res_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: register file and ALU stand-ins,
// an instruction-level reference model checked every cycle, and directed
// vectors with hand-computed results.
`timescale 1ns/1ps

module tb_alu_sequencer;

  localparam logic [4:0] PSR_RST = 5'b01010;
  localparam bit         ILL_WB  = 1'b0;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [3:0]  rf_raddr_a, rf_raddr_b;
  logic [15:0] rf_rdata_a, rf_rdata_b;
  logic [15:0] alu_ctrl, alu_in1, alu_in2, alu_out;
  logic [4:0]  alu_flags;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic [4:0]  psr;
  logic        done, illegal;

  always #5 clk = ~clk;

  alu_sequencer #(.PSR_RESET(PSR_RST), .ILLEGAL_WB(ILL_WB)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b),
    .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b), .alu_ctrl(alu_ctrl),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_out(alu_out), .alu_flags(alu_flags),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .psr(psr),
    .done(done), .illegal(illegal)
  );

  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] init_val(input int i);
    logic [3:0] n;
    n = i[3:0];
    case (i)
      1:       return 16'h0003;
      2:       return 16'h0004;
      3:       return 16'h7FFF;
      4, 5:    return 16'h0010;
      default: return {n, n, n, n};
    endcase
  endfunction

  // Toy ALU: returns {zero, carry, overflow, negative, low, result}
  function automatic logic [20:0] alu_fn(input logic [15:0] ctrl, input logic [15:0] a,
                                         input logic [15:0] b);
    logic [3:0]  sel;
    logic [15:0] opnd, r;
    logic [16:0] wide;
    logic        c, v, lo;
    if (ctrl[15:12] == 4'h0) begin
      sel  = ctrl[7:4];
      opnd = b;
    end else begin
      sel  = ctrl[15:12];
      opnd = {8'h00, ctrl[11:8], ctrl[3:0]};
    end
    c = 1'b0; v = 1'b0; lo = 1'b0;
    case (sel)
      4'h0: r = 16'h0000;
      4'h5: begin
        wide = {1'b0, a} + {1'b0, opnd};
        r = wide[15:0]; c = wide[16];
        v = (a[15] == opnd[15]) && (r[15] != a[15]);
      end
      4'h9, 4'hB, 4'hD, 4'h2: begin
        wide = {1'b0, a} - {1'b0, opnd};
        r = wide[15:0]; c = wide[16];
        v = (a[15] != opnd[15]) && (r[15] != a[15]);
        lo = (a < opnd);
      end
      4'h1:    r = a & opnd;
      4'h3:    r = a | opnd;
      default: r = a ^ opnd;
    endcase
    return {(r == 16'h0000), c, v, r[15], lo, r};
  endfunction

  // Register file stand-in: synchronous read, reloaded on reset
  logic [15:0] rf_mem [16];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) rf_mem[i] <= init_val(i);
    end else if (rf_we) begin
      rf_mem[rf_waddr] <= rf_wdata;
    end
    rf_rdata_a <= rf_mem[rf_raddr_a];
    rf_rdata_b <= rf_mem[rf_raddr_b];
  end

  // ALU stand-in
  always_comb {alu_flags, alu_out} = alu_fn(alu_ctrl, alu_in1, alu_in2);

  // Reference model state (instruction level)
  int          t = 0;
  int          acc = -100;
  bit          started = 1'b0;
  logic [15:0] mdl_rf [16];
  logic [4:0]  mdl_psr;
  logic [3:0]  e_rd, e_rs;
  logic [15:0] e_ctrl, e_a, e_b, e_res;
  logic [4:0]  e_flags;
  bit          e_legal, e_we, e_upd;

  // Observations used by the literal checks
  int          wr_count = 0, ill_count = 0, done_count = 0, last_done_t = 0;
  logic [3:0]  last_waddr = '0;
  logic [15:0] last_wdata = '0, last_exec_ctrl = '0;
  int          acc_q[$];

  task automatic model_reset();
    acc = -100;
    mdl_psr = PSR_RST;
    for (int i = 0; i < 16; i++) mdl_rf[i] = init_val(i);
  endtask

  task automatic model_accept(input logic [15:0] ins);
    logic [3:0] op, ext;
    bit cmp, nop;
    op = ins[15:12]; ext = ins[7:4];
    e_rd = ins[11:8]; e_rs = ins[3:0];
    e_a = mdl_rf[e_rd]; e_b = mdl_rf[e_rs];
    e_legal = (op == 4'h0) || (op inside {4'h1, 4'h2, 4'h3, 4'h5, 4'h6, 4'h7, 4'h9, 4'hB, 4'hE});
    e_ctrl = (op == 4'h0) ? ins : {op, ext, 4'h0, ins[3:0]};
    cmp = (op == 4'h0) ? (ext inside {4'hB, 4'hD}) : (op inside {4'hB, 4'h2});
    nop = (op == 4'h0) && (ext == 4'h0);
    {e_flags, e_res} = alu_fn(e_ctrl, e_a, e_b);
    e_we = e_legal ? !(cmp || nop) : ILL_WB;
    e_upd = e_legal && !nop;
  endtask

  // Compare process: every cycle, outputs against the model
  initial begin
    int  k;
    bit  busy;
    forever begin
      @(negedge clk);
      t++;
      if (!started) begin
        if (reset) begin
          started = 1'b1;
          model_reset();
        end
        continue;
      end
      if (reset) begin
        chk("done_in_reset", done, 0);
        chk("rf_we_in_reset", rf_we, 0);
        chk("illegal_in_reset", illegal, 0);
        model_reset();
        continue;
      end
      k = t - acc;
      busy = (k >= 1) && (k <= 3);
      chk("instr_ready", instr_ready, !busy);
      chk("done", done, k == 3);
      chk("illegal", illegal, (k == 3) && !e_legal);
      chk("rf_we", rf_we, (k == 3) && e_we);
      if ((k == 3) && e_we) begin
        chk("rf_waddr", rf_waddr, e_rd);
        chk("rf_wdata", rf_wdata, e_res);
      end
      chk("alu_ctrl", alu_ctrl, (k == 2) ? e_ctrl : 16'h0000);
      chk("alu_in1", alu_in1, (k == 2) ? e_a : 16'h0000);
      chk("alu_in2", alu_in2, (k == 2) ? e_b : 16'h0000);
      if (k == 1) begin
        chk("rf_raddr_a", rf_raddr_a, e_rd);
        chk("rf_raddr_b", rf_raddr_b, e_rs);
      end
      chk("psr", psr, mdl_psr);
      if (rf_we) begin
        wr_count++; last_waddr = rf_waddr; last_wdata = rf_wdata;
      end
      if (illegal) ill_count++;
      if (done) begin
        done_count++; last_done_t = t;
      end
      if (k == 2) last_exec_ctrl = alu_ctrl;
      if (instr_valid && instr_ready) acc_q.push_back(t);
      if (k == 3) begin
        if (e_we) mdl_rf[e_rd] = e_res;
        if (e_upd) mdl_psr = e_flags;
      end
      if (!busy && instr_valid) begin
        acc = t;
        model_accept(instr);
      end
    end
  end

  task automatic wait_ready();
    bit seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (instr_ready) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk("accept_timeout", 0, 1);
  endtask

  // Issue one instruction and return in the cycle after its writeback
  task automatic issue(input logic [15:0] ins);
    @(posedge clk); #1;
    instr = ins; instr_valid = 1'b1;
    wait_ready();
    @(posedge clk); #1;
    instr_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    $display("instr %h: done_count=%0d wr_count=%0d psr=%b", ins, done_count, wr_count, psr);
  endtask

  initial begin
    logic [15:0] b2b [3];
    int wr0, dn0, n;
    b2b[0] = 16'h0152; b2b[1] = 16'h0252; b2b[2] = 16'h0152;
    reset = 1'b1; instr_valid = 1'b0; instr = 16'h0000;
    repeat (3) begin
      @(posedge clk); #1;
    end
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", instr_ready, 1);
    chk("rst_rf_we", rf_we, 0);
    chk("rst_done", done, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_alu_ctrl", alu_ctrl, 16'h0000);
    chk("rst_raddr_a", rf_raddr_a, 4'h0);
    chk("rst_raddr_b", rf_raddr_b, 4'h0);
    chk("rst_psr", psr, PSR_RST);
    $display("reset released: psr=%b ready=%b", psr, instr_ready);

    issue(16'h0152);                      // ADD R1,R2: 3+4
    chk("add_wr_count", wr_count, 1);
    chk("add_waddr", last_waddr, 4'h1);
    chk("add_wdata", last_wdata, 16'h0007);
    chk("add_psr", psr, 5'b00000);
    chk("add_latency", last_done_t - acc_q[$], 3);

    issue(16'h5301);                      // ADDI R3,#1: 7FFF+1
    chk("addi_ctrl", last_exec_ctrl, 16'h5001);
    chk("addi_waddr", last_waddr, 4'h3);
    chk("addi_wdata", last_wdata, 16'h8000);
    chk("addi_psr_ov", psr[2], 1'b1);
    chk("addi_psr", psr, 5'b00110);

    issue(16'h04B5);                      // CMP R4,R5: equal
    chk("cmp_wr_count", wr_count, 2);
    chk("cmp_psr", psr, 5'b10000);
    chk("cmp_done_count", done_count, 3);

    issue(16'hC123);                      // undefined opcode
    chk("ill_count", ill_count, 1);
    chk("ill_wr_count", wr_count, 2);
    chk("ill_psr", psr, 5'b10000);

    issue(16'h0000);                      // NOP
    chk("nop_wr_count", wr_count, 2);
    chk("nop_psr", psr, 5'b10000);
    chk("nop_done_count", done_count, 5);

    issue(16'h9412);                      // SUBI R4,#12: 0010-0012
    chk("subi_wdata", last_wdata, 16'hFFFE);
    chk("subi_psr", psr, 5'b01011);

    // Back-to-back with instr_valid held high
    @(posedge clk); #1;
    instr_valid = 1'b1; instr = b2b[0];
    for (int j = 0; j < 3; j++) begin
      wait_ready();
      @(posedge clk); #1;
      if (j < 2) instr = b2b[j + 1];
      else instr_valid = 1'b0;
    end
    repeat (3) begin
      @(posedge clk); #1;
    end
    n = acc_q.size();
    chk("b2b_gap1", acc_q[n-2] - acc_q[n-3], 4);
    chk("b2b_gap2", acc_q[n-1] - acc_q[n-2], 4);
    chk("b2b_wdata", last_wdata, 16'h0013);   // R1 = 000B + 0008
    $display("back-to-back accepts at cycles %0d %0d %0d", acc_q[n-3], acc_q[n-2], acc_q[n-1]);

    // Reset during EXEC aborts the instruction
    wr0 = wr_count; dn0 = done_count;
    @(posedge clk); #1;
    instr_valid = 1'b1; instr = 16'h0152;
    wait_ready();
    @(posedge clk); #1;
    instr_valid = 1'b0;                   // now READ
    @(posedge clk); #1;
    reset = 1'b1;                         // now EXEC
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("abort_ready", instr_ready, 1);
    chk("abort_psr", psr, PSR_RST);
    chk("abort_alu_ctrl", alu_ctrl, 16'h0000);
    repeat (4) begin
      @(posedge clk); #1;
    end
    chk("abort_wr_count", wr_count, wr0);
    chk("abort_done_count", done_count, dn0);
    $display("reset in EXEC: psr=%b wr_count=%0d", psr, wr_count);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
